// File: rtl/rx_pkg.sv
// Shared definitions for the UART Rx frame checker: parity encodings,
// error/status bit positions and the output-buffer state type.
package rx_pkg;

  localparam logic [1:0] PAR_NONE0 = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE1 = 2'b11;

  localparam int unsigned ERR_PARITY  = 0;
  localparam int unsigned ERR_START   = 1;
  localparam int unsigned ERR_STOP    = 2;
  localparam int unsigned ERR_BREAK   = 3;
  localparam int unsigned STS_OVERRUN = 4;

  localparam int unsigned ERR_W = 4;
  localparam int unsigned STS_W = 5;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } bufState_t;

  function automatic logic parityEnabled(input logic [1:0] parityType);
    return (parityType == PAR_ODD) || (parityType == PAR_EVEN);
  endfunction

endpackage

// File: rtl/rx_frame_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Inc,
  input  logic             Clr,
  output logic [WIDTH-1:0] Count
);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      Count <= '0;
    end else if (Clr) begin
      Count <= '0;
    end else if (Inc && (Count != {WIDTH{1'b1}})) begin
      Count <= Count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/rx_frame_checker.sv
// UART Rx frame checker: flags parity/start/stop/break errors and holds one
// frame in a valid/ready buffer. Define RX_FRAME_CHECKER_ERR_COUNT_EN for counters.
module rx_frame_checker
  import rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_MAX   = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  FrameValid,
  input  logic                  StartBit,
  input  logic [DATA_WIDTH-1:0] RawData,
  input  logic                  ParityBit,
  input  logic [STOP_MAX-1:0]   StopBits,
  input  logic [1:0]            ParityType,
  input  logic                  TwoStop,
  input  logic                  OutReady,
  output logic                  OutValid,
  output logic [DATA_WIDTH-1:0] OutData,
  output logic [ERR_W-1:0]      ErrorFlag,
  output logic                  Overrun,
  output logic [STS_W-1:0]      StickyStatus,
  input  logic                  ClearStatus
`ifdef RX_FRAME_CHECKER_ERR_COUNT_EN
  ,
  input  logic                  ClearCount,
  output logic [CNT_WIDTH-1:0]  ParityErrCount,
  output logic [CNT_WIDTH-1:0]  FrameErrCount,
  output logic [CNT_WIDTH-1:0]  OverrunCount
`endif
);

  bufState_t        state;
  bufState_t        nextState;
  logic             loadFrame;
  logic             dropFrame;
  logic [ERR_W-1:0] frameFlags;

  logic parityOn;
  logic expParity;
  logic useSecondStop;
  logic secondStopLow;
  logic stopErr;
  logic isBreak;

  // Frame checks evaluated on the incoming fields; only used when FrameValid.
  always_comb begin
    parityOn      = parityEnabled(ParityType);
    expParity     = (ParityType == PAR_ODD) ? ~^RawData : ^RawData;
    useSecondStop = (STOP_MAX >= 2) ? TwoStop : 1'b0;
    secondStopLow = ~StopBits[STOP_MAX-1];
    stopErr       = ~StopBits[0] | (useSecondStop & secondStopLow);
    isBreak       = ~StartBit
                  & (RawData == '0)
                  & (~parityOn | ~ParityBit)
                  & ~StopBits[0]
                  & (~useSecondStop | secondStopLow);

    frameFlags             = '0;
    frameFlags[ERR_PARITY] = parityOn & (ParityBit != expParity);
    frameFlags[ERR_START]  = StartBit;
    frameFlags[ERR_STOP]   = stopErr & ~isBreak;
    frameFlags[ERR_BREAK]  = isBreak;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state <= BUF_EMPTY;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      BUF_EMPTY: if (FrameValid)               nextState = BUF_FULL;
      BUF_FULL:  if (OutReady && !FrameValid)  nextState = BUF_EMPTY;
      default:                                 nextState = BUF_EMPTY;
    endcase
  end

  // A full buffer only takes a new frame when the consumer drains it the same cycle.
  always_comb begin
    loadFrame = 1'b0;
    dropFrame = 1'b0;
    case (state)
      BUF_EMPTY: loadFrame = FrameValid;
      BUF_FULL: begin
        loadFrame = FrameValid & OutReady;
        dropFrame = FrameValid & ~OutReady;
      end
      default: ;
    endcase
  end

  assign OutValid = (state == BUF_FULL);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      OutData      <= '0;
      ErrorFlag    <= '0;
      Overrun      <= 1'b0;
      StickyStatus <= '0;
    end else begin
      if (loadFrame) begin
        OutData   <= RawData;
        ErrorFlag <= frameFlags;
      end
      Overrun <= dropFrame;
      if (ClearStatus) begin
        StickyStatus <= '0;
      end else begin
        StickyStatus <= StickyStatus | {dropFrame, (loadFrame ? frameFlags : ERR_W'(0))};
      end
    end
  end

`ifdef RX_FRAME_CHECKER_ERR_COUNT_EN
  logic parityInc;
  logic frameInc;

  assign parityInc = loadFrame & frameFlags[ERR_PARITY];
  assign frameInc  = loadFrame & (frameFlags[ERR_START] | frameFlags[ERR_STOP] | frameFlags[ERR_BREAK]);

  sat_counter #(.WIDTH(CNT_WIDTH)) uParityCnt (
    .Clock  (Clock),
    .ResetN (ResetN),
    .Inc    (parityInc),
    .Clr    (ClearCount),
    .Count  (ParityErrCount)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) uFrameCnt (
    .Clock  (Clock),
    .ResetN (ResetN),
    .Inc    (frameInc),
    .Clr    (ClearCount),
    .Count  (FrameErrCount)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) uOverrunCnt (
    .Clock  (Clock),
    .ResetN (ResetN),
    .Inc    (dropFrame),
    .Clr    (ClearCount),
    .Count  (OverrunCount)
  );
`endif

endmodule

// File: tb/tb_rx_frame_checker.sv
// Directed testbench for rx_frame_checker with a frame-level reference model;
// counter checks are active when RX_FRAME_CHECKER_ERR_COUNT_EN is defined.
module tb_rx_frame_checker;
  import rx_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned SM = 2;
  localparam int unsigned CW = 2;

  logic          Clock = 1'b0;
  logic          ResetN = 1'b0;
  logic          FrameValid = 1'b0;
  logic          StartBit = 1'b0;
  logic [DW-1:0] RawData = '0;
  logic          ParityBit = 1'b0;
  logic [SM-1:0] StopBits = '1;
  logic [1:0]    ParityType = PAR_NONE0;
  logic          TwoStop = 1'b0;
  logic          OutReady = 1'b0;
  logic          ClearStatus = 1'b0;
  logic          ClearCount = 1'b0;
  logic          OutValid;
  logic [DW-1:0] OutData;
  logic [3:0]    ErrorFlag;
  logic          Overrun;
  logic [4:0]    StickyStatus;
  logic [CW-1:0] ParityErrCount;
  logic [CW-1:0] FrameErrCount;
  logic [CW-1:0] OverrunCount;

  rx_frame_checker #(.DATA_WIDTH(DW), .STOP_MAX(SM), .CNT_WIDTH(CW)) dut (
    .Clock        (Clock),
    .ResetN       (ResetN),
    .FrameValid   (FrameValid),
    .StartBit     (StartBit),
    .RawData      (RawData),
    .ParityBit    (ParityBit),
    .StopBits     (StopBits),
    .ParityType   (ParityType),
    .TwoStop      (TwoStop),
    .OutReady     (OutReady),
    .OutValid     (OutValid),
    .OutData      (OutData),
    .ErrorFlag    (ErrorFlag),
    .Overrun      (Overrun),
    .StickyStatus (StickyStatus),
    .ClearStatus  (ClearStatus)
`ifdef RX_FRAME_CHECKER_ERR_COUNT_EN
    ,
    .ClearCount     (ClearCount),
    .ParityErrCount (ParityErrCount),
    .FrameErrCount  (FrameErrCount),
    .OverrunCount   (OverrunCount)
`endif
  );

  always #5 Clock = ~Clock;

  int nCompared = 0;
  int nMismatched = 0;
  bit checkOn = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what one accepted frame must report.
  function automatic logic [3:0] modelFlags(input logic st, input logic [DW-1:0] d,
                                            input logic p, input logic [SM-1:0] sb,
                                            input logic [1:0] pt, input logic two);
    int  ones;
    bit  pOn, expP, perr, stopBad, brk;
    ones    = $countones(d);
    pOn     = (pt == PAR_ODD) || (pt == PAR_EVEN);
    expP    = (pt == PAR_ODD) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    perr    = pOn && (p != expP);
    stopBad = (sb[0] == 1'b0) || (two && sb[1] == 1'b0);
    brk     = (st == 1'b0) && (d == 0) && (!pOn || p == 1'b0) &&
              (sb[0] == 1'b0) && (!two || sb[1] == 1'b0);
    return {brk, stopBad && !brk, st, perr};
  endfunction

  function automatic int satStep(input int c, input bit inc, input bit clr);
    if (clr) return 0;
    if (inc && c < (1 << CW) - 1) return c + 1;
    return c;
  endfunction

  bit          mValid = 1'b0;
  logic [7:0]  mData = '0;
  logic [3:0]  mFlags = '0;
  bit          mOverrun = 1'b0;
  logic [4:0]  mSticky = '0;
  int          mParCnt = 0, mFrmCnt = 0, mOvrCnt = 0;

  always @(posedge Clock or negedge ResetN) begin
    bit ld, dp;
    logic [3:0] f;
    if (!ResetN) begin
      mValid = 0; mData = '0; mFlags = '0; mOverrun = 0; mSticky = '0;
      mParCnt = 0; mFrmCnt = 0; mOvrCnt = 0;
    end else begin
      f  = modelFlags(StartBit, RawData, ParityBit, StopBits, ParityType, TwoStop);
      ld = FrameValid && (!mValid || OutReady);
      dp = FrameValid && mValid && !OutReady;
      if (ld) begin
        mData  = RawData;
        mFlags = f;
      end
      mValid   = ld || (mValid && !OutReady);
      mOverrun = dp;
      mSticky  = ClearStatus ? 5'b0 : (mSticky | {dp, (ld ? f : 4'b0)});
      mParCnt  = satStep(mParCnt, ld && f[0], ClearCount);
      mFrmCnt  = satStep(mFrmCnt, ld && (f[3:1] != 0), ClearCount);
      mOvrCnt  = satStep(mOvrCnt, dp, ClearCount);
    end
  end

  always @(negedge Clock) begin
    if (checkOn) begin
      check("OutValid", 32'(OutValid), 32'(mValid));
      if (mValid) begin
        check("OutData", 32'(OutData), 32'(mData));
        check("ErrorFlag", 32'(ErrorFlag), 32'(mFlags));
      end
      check("Overrun", 32'(Overrun), 32'(mOverrun));
      check("StickyStatus", 32'(StickyStatus), 32'(mSticky));
`ifdef RX_FRAME_CHECKER_ERR_COUNT_EN
      check("ParityErrCount", 32'(ParityErrCount), 32'(mParCnt));
      check("FrameErrCount", 32'(FrameErrCount), 32'(mFrmCnt));
      check("OverrunCount", 32'(OverrunCount), 32'(mOvrCnt));
`endif
    end
  end

  task automatic drive(input logic fv, input logic st, input logic [DW-1:0] d, input logic p,
                       input logic [SM-1:0] sb, input logic [1:0] pt, input logic two,
                       input logic rdy, input logic cs, input logic cc);
    FrameValid = fv; StartBit = st; RawData = d; ParityBit = p; StopBits = sb;
    ParityType = pt; TwoStop = two; OutReady = rdy; ClearStatus = cs; ClearCount = cc;
    @(negedge Clock);
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 2'b11, PAR_NONE0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge Clock);
    ResetN = 1'b1;
    checkOn = 1'b1;
    check("rst_valid", 32'(OutValid), 0);
    check("rst_data", 32'(OutData), 0);
    check("rst_flags", 32'(ErrorFlag), 0);
    check("rst_sticky", 32'(StickyStatus), 0);

    // Clean even-parity frame, one-cycle latency
    drive(1, 0, 8'hA5, 0, 2'b11, PAR_EVEN, 0, 0, 0, 0);
    check("t1_valid", 32'(OutValid), 1);
    check("t1_data", 32'(OutData), 32'h A5);
    check("t1_flags", 32'(ErrorFlag), 32'b0000);
    idle(1);
    check("t1_drain", 32'(OutValid), 0);

    // Odd-parity error
    drive(1, 0, 8'h01, 1, 2'b11, PAR_ODD, 0, 1, 0, 0);
    check("t2_flags", 32'(ErrorFlag), 32'b0001);
    check("t2_sticky0", 32'(StickyStatus[0]), 1);
`ifdef RX_FRAME_CHECKER_ERR_COUNT_EN
    check("t2_parcnt", 32'(ParityErrCount), 1);
`endif

    // Second stop bit low, then a break frame (reload while draining)
    drive(1, 0, 8'hA5, 0, 2'b01, PAR_EVEN, 1, 1, 0, 0);
    check("t3_stop", 32'(ErrorFlag), 32'b0100);
    check("t3_no_ovr", 32'(Overrun), 0);
    drive(1, 0, 8'h00, 0, 2'b00, PAR_NONE0, 1, 1, 0, 0);
    check("t3_break", 32'(ErrorFlag), 32'b1000);
    check("t3_sticky", 32'(StickyStatus), 32'h0D);
    // Break with only first stop bit checked; ParityBit ignored with parity off
    drive(1, 0, 8'h00, 1, 2'b10, PAR_NONE1, 0, 1, 0, 0);
    check("t3_break1", 32'(ErrorFlag), 32'b1000);
    // ParityBit high defeats break: stop and parity errors instead
    drive(1, 0, 8'h00, 1, 2'b10, PAR_EVEN, 0, 1, 0, 0);
    check("t3_nobreak", 32'(ErrorFlag), 32'b0101);
    idle(1);
    drive(0, 0, 8'h00, 0, 2'b11, PAR_NONE0, 0, 1, 1, 0);
    check("t3_clear", 32'(StickyStatus), 0);

    // Overrun while held, then same-cycle drain and reload
    drive(1, 0, 8'h11, 0, 2'b11, PAR_EVEN, 0, 0, 0, 0);
    check("t4_load", 32'(OutData), 32'h11);
    drive(1, 0, 8'h22, 0, 2'b11, PAR_EVEN, 0, 0, 0, 0);
    check("t4_ovr", 32'(Overrun), 1);
    check("t4_keep", 32'(OutData), 32'h11);
    check("t4_sticky4", 32'(StickyStatus[4]), 1);
    idle(0);
    check("t4_ovr_pulse", 32'(Overrun), 0);
    check("t4_hold", 32'(OutData), 32'h11);
    drive(1, 0, 8'h22, 0, 2'b11, PAR_EVEN, 0, 1, 0, 0);
    check("t4_swap", 32'(OutData), 32'h22);
    check("t4_swap_ovr", 32'(Overrun), 0);
    idle(1);

    // ClearStatus beats a coincident error
    drive(1, 0, 8'h01, 1, 2'b11, PAR_ODD, 0, 1, 1, 0);
    check("t4_clr_win", 32'(StickyStatus), 0);
    check("t4_clr_flags", 32'(ErrorFlag), 32'b0001);
    idle(1);

    // Saturation of parity error counter, then ClearCount wins
    drive(0, 0, 8'h00, 0, 2'b11, PAR_NONE0, 0, 1, 0, 1);
    repeat (5) drive(1, 0, 8'h01, 1, 2'b11, PAR_ODD, 0, 1, 0, 0);
`ifdef RX_FRAME_CHECKER_ERR_COUNT_EN
    check("t5_sat", 32'(ParityErrCount), 3);
`endif
    drive(1, 0, 8'h01, 1, 2'b11, PAR_ODD, 0, 1, 0, 1);
`ifdef RX_FRAME_CHECKER_ERR_COUNT_EN
    check("t5_clr", 32'(ParityErrCount), 0);
`endif
    idle(1);

    // Async reset while full
    drive(1, 1, 8'h5A, 0, 2'b11, PAR_EVEN, 0, 0, 0, 0);
    check("t6_full", 32'(ErrorFlag), 32'b0010);
    #2 ResetN = 1'b0;
    #1;
    check("t6_rst_valid", 32'(OutValid), 0);
    check("t6_rst_flags", 32'(ErrorFlag), 0);
    @(negedge Clock);
    ResetN = 1'b1;
    idle(0);
    check("t6_no_pending", 32'(OutValid), 0);
    idle(0);

    checkOn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
